bip_control: RTL and testbench

BIP_CONTROL -- requirements
Module: bip_control

---
 rtl/bip_control.sv | 190 +++++++++++++++++++
 tb/tb_bip_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// ============================================================================
// Module   : bip_control
// Purpose  : Multi-cycle control FSM for the BIP accumulator processor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bip_control #(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_valid_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [PC_W-1:0]    dmem_addr_o,
  output logic               dmem_rd_o,
  output logic               dmem_wr_o,
  output logic               alu_op_o,
  output logic               sel_b_o,
  output logic [15:0]        imm_o,
  output logic [1:0]         acc_src_o,
  output logic               acc_wr_o,
  output logic               halted_o
);

  localparam int c_OPC_W  = 5;
  localparam int c_OPND_W = INSTR_W - c_OPC_W;

  localparam logic [4:0] c_OP_HLT  = 5'b00000;
  localparam logic [4:0] c_OP_STO  = 5'b00001;
  localparam logic [4:0] c_OP_LD   = 5'b00010;
  localparam logic [4:0] c_OP_LDI  = 5'b00011;
  localparam logic [4:0] c_OP_ADD  = 5'b00100;
  localparam logic [4:0] c_OP_ADDI = 5'b00101;
  localparam logic [4:0] c_OP_SUB  = 5'b00110;
  localparam logic [4:0] c_OP_SUBI = 5'b00111;

  localparam logic [1:0] c_SRC_ALU = 2'b00;
  localparam logic [1:0] c_SRC_MEM = 2'b01;
  localparam logic [1:0] c_SRC_IMM = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       dmem_rd;
    logic       dmem_wr;
    logic       acc_wr;
    logic       alu_op;
    logic       sel_b;
    logic [1:0] acc_src;
  } ctrl_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_imem_req;
  ctrl_t               r_ctrl;
  logic [PC_W-1:0]     r_dmem_addr;
  logic [15:0]         r_imm;
  logic                r_halted;

  logic [4:0]          w_in_op;
  logic [c_OPND_W-1:0] w_in_opnd;
  logic [4:0]          w_ir_op;
  logic [c_OPND_W-1:0] w_ir_opnd;

  assign w_in_op   = imem_data_i[INSTR_W-1 -: c_OPC_W];
  assign w_in_opnd = imem_data_i[c_OPND_W-1:0];
  assign w_ir_op   = r_ir[INSTR_W-1 -: c_OPC_W];
  assign w_ir_opnd = r_ir[c_OPND_W-1:0];

  // Strobes for the EXEC cycle; memory-operand ops only issue the read here.
  function automatic ctrl_t exec_ctrl(input logic [4:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      c_OP_STO:  c.dmem_wr = 1'b1;
      c_OP_LDI:  begin c.acc_src = c_SRC_IMM; c.acc_wr = 1'b1; end
      c_OP_ADDI: begin c.alu_op = 1'b1; c.sel_b = 1'b1; c.acc_src = c_SRC_ALU; c.acc_wr = 1'b1; end
      c_OP_SUBI: begin c.alu_op = 1'b0; c.sel_b = 1'b1; c.acc_src = c_SRC_ALU; c.acc_wr = 1'b1; end
      c_OP_LD, c_OP_ADD, c_OP_SUB: c.dmem_rd = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Write-back strobes, one cycle after the data read was issued.
  function automatic ctrl_t wb_ctrl(input logic [4:0] op);
    ctrl_t c;
    c        = '0;
    c.acc_wr = 1'b1;
    case (op)
      c_OP_LD:  c.acc_src = c_SRC_MEM;
      c_OP_ADD: c.alu_op  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == c_OP_LD) || (op == c_OP_ADD) || (op == c_OP_SUB);
  endfunction

  function automatic logic [15:0] sext_imm(input logic [c_OPND_W-1:0] opnd);
    return 16'($signed(opnd));
  endfunction

  function automatic logic [PC_W-1:0] to_addr(input logic [c_OPND_W-1:0] opnd);
    return PC_W'(opnd);
  endfunction

  // Outputs are registered alongside the state so they are glitch-free and
  // cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_imem_req  <= 1'b0;
      r_ctrl      <= '0;
      r_dmem_addr <= '0;
      r_imm       <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_ctrl      <= '0;
      r_imem_req  <= 1'b0;
      r_dmem_addr <= '0;
      r_imm       <= '0;
      case (r_state)
        S_FETCH: begin
          if (r_imem_req && imem_valid_i) begin
            r_ir        <= imem_data_i;
            r_state     <= S_EXEC;
            r_ctrl      <= exec_ctrl(w_in_op);
            r_dmem_addr <= to_addr(w_in_opnd);
            r_imm       <= sext_imm(w_in_opnd);
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_ir_op == c_OP_HLT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (is_mem_op(w_ir_op)) begin
            r_state     <= S_WB;
            r_ctrl      <= wb_ctrl(w_ir_op);
            r_dmem_addr <= to_addr(w_ir_opnd);
            r_imm       <= sext_imm(w_ir_opnd);
          end else begin
            r_pc       <= r_pc + PC_W'(1);
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_WB: begin
          r_pc       <= r_pc + PC_W'(1);
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req_o  = r_imem_req;
  assign imem_addr_o = r_pc;
  assign dmem_addr_o = r_dmem_addr;
  assign dmem_rd_o   = r_ctrl.dmem_rd;
  assign dmem_wr_o   = r_ctrl.dmem_wr;
  assign alu_op_o    = r_ctrl.alu_op;
  assign sel_b_o     = r_ctrl.sel_b;
  assign imm_o       = r_imm;
  assign acc_src_o   = r_ctrl.acc_src;
  assign acc_wr_o    = r_ctrl.acc_wr;
  assign halted_o    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_bip_control.sv
// ============================================================================
// Module   : tb_bip_control
// Purpose  : Self-checking bench for bip_control against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bip_control;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [10:0] imem_addr_o;
  logic        imem_valid_i;
  logic [15:0] imem_data_i;
  logic [10:0] dmem_addr_o;
  logic        dmem_rd_o;
  logic        dmem_wr_o;
  logic        alu_op_o;
  logic        sel_b_o;
  logic [15:0] imm_o;
  logic [1:0]  acc_src_o;
  logic        acc_wr_o;
  logic        halted_o;

  int tests = 0;
  int fails = 0;
  int exp_pc = 0;

  always #5 clk_i = ~clk_i;

  bip_control #(.PC_W(11), .INSTR_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
    .dmem_addr_o(dmem_addr_o), .dmem_rd_o(dmem_rd_o), .dmem_wr_o(dmem_wr_o),
    .alu_op_o(alu_op_o), .sel_b_o(sel_b_o), .imm_o(imm_o),
    .acc_src_o(acc_src_o), .acc_wr_o(acc_wr_o), .halted_o(halted_o)
  );

  // {req, addr, rd, wr, daddr, alu, selb, imm, src, accwr, halted}
  function automatic logic [46:0] pack(input logic req, input logic [10:0] addr,
      input logic rd, input logic wr, input logic [10:0] da, input logic alu,
      input logic selb, input logic [15:0] imm, input logic [1:0] src,
      input logic accwr, input logic hlt);
    return {req, addr, rd, wr, da, alu, selb, imm, src, accwr, hlt};
  endfunction

  function automatic logic [46:0] obs();
    return {imem_req_o, imem_addr_o, dmem_rd_o, dmem_wr_o, dmem_addr_o, alu_op_o,
            sel_b_o, imm_o, acc_src_o, acc_wr_o, halted_o};
  endfunction

  function automatic logic [46:0] exp_fetch(input int pc);
    return pack(1'b1, 11'(pc), 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [46:0] exp_halt(input int pc);
    return pack(1'b0, 11'(pc), 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b1);
  endfunction

  function automatic bit is_mem(input logic [15:0] instr);
    int op;
    op = int'(instr[15:11]);
    return (op == 2) || (op == 4) || (op == 6);
  endfunction

  function automatic logic [46:0] exp_exec(input logic [15:0] instr, input int pc);
    int op;
    logic rd, wr, alu, selb, accwr;
    logic [1:0] src;
    logic [15:0] imm;
    op = int'(instr[15:11]);
    rd = 0; wr = 0; alu = 0; selb = 0; accwr = 0; src = 2'd0;
    imm = {{5{instr[10]}}, instr[10:0]};
    case (op)
      1: wr = 1;
      3: begin src = 2'd2; accwr = 1; end
      5: begin alu = 1; selb = 1; accwr = 1; end
      7: begin selb = 1; accwr = 1; end
      2, 4, 6: rd = 1;
      default: ;
    endcase
    return pack(1'b0, 11'(pc), rd, wr, instr[10:0], alu, selb, imm, src, accwr, 1'b0);
  endfunction

  function automatic logic [46:0] exp_wb(input logic [15:0] instr, input int pc);
    int op;
    op = int'(instr[15:11]);
    return pack(1'b0, 11'(pc), 1'b0, 1'b0, instr[10:0], op == 4, 1'b0,
                {{5{instr[10]}}, instr[10:0]}, (op == 2) ? 2'd1 : 2'd0, 1'b1, 1'b0);
  endfunction

  // Runs one instruction through fetch (with delay wait cycles), EXEC and WB.
  task automatic run_instr(input logic [15:0] instr, input int delay, input string tag,
                           input bit reset_in_wb);
    logic [46:0] e;
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk_i);
      e = exp_fetch(exp_pc);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL %s fetch_wait%0d: got %h want %h", tag, k, obs(), e);
      end
      imem_valid_i = (k == delay);
      imem_data_i  = (k == delay) ? instr : 16'($urandom);
    end
    @(negedge clk_i);
    e = exp_exec(instr, exp_pc);
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL %s exec: got %h want %h", tag, obs(), e);
    end
    imem_valid_i = 1'($urandom);
    imem_data_i  = 16'($urandom);
    if (is_mem(instr)) begin
      @(negedge clk_i);
      e = exp_wb(instr, exp_pc);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL %s wb: got %h want %h", tag, obs(), e);
      end
      imem_valid_i = 1'($urandom);
      if (reset_in_wb) begin
        #1 rst_ni = 1'b0;
        #1;
        tests++;
        if (obs() !== 47'd0) begin
          fails++;
          $display("FAIL %s async_reset: got %h want 0", tag, obs());
        end
        @(negedge clk_i);
        tests++;
        if (obs() !== 47'd0) begin
          fails++;
          $display("FAIL %s held_reset: got %h want 0", tag, obs());
        end
        rst_ni       = 1'b1;
        imem_valid_i = 1'b0;
        exp_pc       = 0;
        return;
      end
    end
    if (instr[15:11] != 5'd0) exp_pc = (exp_pc + 1) % 2048;
  endtask

  task automatic test_reset();
    rst_ni       = 1'b0;
    imem_valid_i = 1'b1;
    imem_data_i  = 16'h1805;
    repeat (2) @(negedge clk_i);
    tests++;
    if (obs() !== 47'd0) begin
      fails++;
      $display("FAIL reset_state: got %h want 0", obs());
    end
    rst_ni       = 1'b1;
    imem_valid_i = 1'b0;
    #1;
    tests++;
    if (obs() !== 47'd0) begin
      fails++;
      $display("FAIL reset_release: got %h want 0", obs());
    end
    exp_pc = 0;
  endtask

  task automatic test_directed();
    run_instr(16'h1805, 0, "ldi5", 1'b0);
    run_instr(16'h3FFF, 1, "subi_m1", 1'b0);
    run_instr(16'h2010, 3, "add_wait3", 1'b0);
  endtask

  task automatic test_random_to_wrap();
    logic [15:0] instr;
    int guard = 0;
    while (exp_pc != 2047 && guard < 5000) begin
      instr = {5'($urandom_range(1, 31)), 11'($urandom)};
      run_instr(instr, $urandom_range(0, 3), "random", 1'b0);
      guard++;
    end
    tests++;
    if (exp_pc != 2047) begin
      fails++;
      $display("FAIL reach_2047: got pc %0d want 2047", exp_pc);
    end
  endtask

  task automatic test_pc_wrap();
    run_instr(16'h0FFF, 0, "sto_7ff", 1'b0);
    @(negedge clk_i);
    imem_valid_i = 1'b0;
    tests++;
    if (imem_addr_o !== 11'd0 || imem_req_o !== 1'b1) begin
      fails++;
      $display("FAIL pc_wrap: got addr %h req %b want 000 1", imem_addr_o, imem_req_o);
    end
  endtask

  task automatic test_reset_mid_wb();
    run_instr({5'b00010, 11'($urandom)}, 1, "ld_reset", 1'b1);
    for (int i = 0; i < 10; i++)
      run_instr({5'($urandom_range(1, 31)), 11'($urandom)}, $urandom_range(0, 2),
                "post_reset", 1'b0);
  endtask

  task automatic test_halt();
    logic [46:0] e;
    run_instr(16'h0000, 2, "hlt", 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      e = exp_halt(exp_pc);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL halt_cycle%0d: got %h want %h", i, obs(), e);
      end
      imem_valid_i = ~imem_valid_i;
      imem_data_i  = 16'($urandom);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random_to_wrap();
    test_pc_wrap();
    test_reset_mid_wb();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
